morra_match_driver: RTL and testbench

// Upstream driver for the MorraCinese game FSMD: accepts queued (P1,P2) moves on a valid/ready port.

---
 rtl/morra_match_driver_if.sv | 11 +
 rtl/morra_match_driver.sv | 155 +++++++++++++++
 tb/tb_morra_match_driver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/morra_match_driver_if.sv
// Move command port between the move source and the Morra match driver.
// The source presents a (P1,P2) move pair with cmd_valid; the driver takes it when cmd_ready is high.
interface morra_match_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_p1;
  logic [1:0] cmd_p2;

  modport master (output cmd_valid, cmd_p1, cmd_p2, input cmd_ready);
  modport slave  (input cmd_valid, cmd_p1, cmd_p2, output cmd_ready);
endinterface

// File: rtl/morra_match_driver.sv
// Queues moves, drives START/P1/P2 into the MorraCinese core and tallies a best-of-N match.
// A queued move is popped at the FETCH edge, and its result is counted 2 cycles later. cmd_ready = !fifo_full, and pushes are accepted in every state.
module morra_match_driver #(
  parameter int FIFO_DEPTH  = 4,
  parameter int MATCH_GAMES = 3,
  parameter int ROUND_LIMIT = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 match_start,
  morra_match_driver_if.slave  cmd,
  output logic [1:0]           game_P1,
  output logic [1:0]           game_P2,
  output logic                 game_START,
  input  logic [1:0]           game_ROUND,
  input  logic [1:0]           game_GAME,
  output logic [3:0]           wins_p1,
  output logic [3:0]           wins_p2,
  output logic [3:0]           games_played,
  output logic                 busy,
  output logic                 match_done,
  output logic [1:0]           match_winner,
  output logic                 timeout_err
);

  localparam int              AW     = $clog2(FIFO_DEPTH);
  localparam int              RW     = $clog2(ROUND_LIMIT + 1);
  localparam logic [3:0]      TARGET = 4'(MATCH_GAMES / 2 + 1);
  localparam logic [3:0]      NGAMES = 4'(MATCH_GAMES);
  localparam logic [RW-1:0]   RLIMIT = RW'(ROUND_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH, S_DRIVE, S_CHECK, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [3:0]    head;
  logic [RW-1:0] round_cnt, round_nxt;
  logic [3:0]    wins_p1_nxt, wins_p2_nxt, games_nxt;
  logic [1:0]    winner_nxt;
  logic          terr_nxt;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign pop           = (state == S_FETCH) && !empty;
  assign head          = mem[rd_ptr[AW-1:0]];

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign match_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd.cmd_p1, cmd.cmd_p2};
  end

  always_comb begin
    state_nxt   = state;
    round_nxt   = round_cnt;
    wins_p1_nxt = wins_p1;
    wins_p2_nxt = wins_p2;
    games_nxt   = games_played;
    winner_nxt  = match_winner;
    terr_nxt    = timeout_err;
    case (state)
      S_IDLE, S_DONE: begin
        if (match_start) begin
          state_nxt   = S_START;
          wins_p1_nxt = '0;
          wins_p2_nxt = '0;
          games_nxt   = '0;
          winner_nxt  = 2'b00;
          terr_nxt    = 1'b0;
        end
      end
      S_START: begin
        state_nxt = S_FETCH;
        round_nxt = '0;
      end
      S_FETCH: if (!empty) state_nxt = S_DRIVE;
      S_DRIVE: state_nxt = S_CHECK;
      S_CHECK: begin
        if (game_GAME == 2'b00) begin
          round_nxt = round_cnt + 1'b1;
          if (round_nxt == RLIMIT) begin
            terr_nxt   = 1'b1;
            winner_nxt = 2'b00;
            state_nxt  = S_DONE;
          end else begin
            state_nxt = S_FETCH;
          end
        end else begin
          games_nxt = games_played + 1'b1;
          if (game_GAME == 2'b01) wins_p1_nxt = wins_p1 + 1'b1;
          if (game_GAME == 2'b10) wins_p2_nxt = wins_p2 + 1'b1;
          if (wins_p1_nxt == TARGET) begin
            winner_nxt = 2'b01;
            state_nxt  = S_DONE;
          end else if (wins_p2_nxt == TARGET) begin
            winner_nxt = 2'b10;
            state_nxt  = S_DONE;
          end else if (games_nxt == NGAMES) begin
            state_nxt = S_DONE;
            if (wins_p1_nxt > wins_p2_nxt)      winner_nxt = 2'b01;
            else if (wins_p2_nxt > wins_p1_nxt) winner_nxt = 2'b10;
            else                                winner_nxt = 2'b11;
          end else begin
            state_nxt = S_START;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      round_cnt    <= '0;
      wins_p1      <= '0;
      wins_p2      <= '0;
      games_played <= '0;
      match_winner <= 2'b00;
      timeout_err  <= 1'b0;
      game_START   <= 1'b0;
      game_P1      <= 2'b00;
      game_P2      <= 2'b00;
    end else begin
      state        <= state_nxt;
      round_cnt    <= round_nxt;
      wins_p1      <= wins_p1_nxt;
      wins_p2      <= wins_p2_nxt;
      games_played <= games_nxt;
      match_winner <= winner_nxt;
      timeout_err  <= terr_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Core outputs follow the next state so they are valid for the whole state cycle.
      game_START   <= (state_nxt == S_START);
      game_P1      <= (state_nxt == S_DRIVE) ? head[3:2] : 2'b00;
      game_P2      <= (state_nxt == S_DRIVE) ? head[1:0] : 2'b00;
    end
  end

  // ROUND is observed for debug only; it must at least be driven when a result is sampled.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state == S_CHECK) |-> !$isunknown(game_ROUND));

endmodule

// File: tb/tb_morra_match_driver.sv
// Directed bench: plays the core from a scripted result queue and checks match tallies, FIFO and reset.
module tb_morra_match_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       match_start;
  logic [1:0] game_P1, game_P2, game_ROUND, game_GAME;
  logic       game_START;
  logic [3:0] wins_p1, wins_p2, games_played;
  logic       busy, match_done, timeout_err;
  logic [1:0] match_winner;

  int         errs = 0;
  int         checks = 0;
  int         start_cnt = 0;
  logic       prev_drive = 1'b0;
  logic [1:0] res_q [$];
  logic [3:0] cap_q [$];
  int         base;

  morra_match_driver_if mif ();

  morra_match_driver #(.FIFO_DEPTH(4), .MATCH_GAMES(3), .ROUND_LIMIT(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .match_start  (match_start),
    .cmd          (mif),
    .game_P1      (game_P1),
    .game_P2      (game_P2),
    .game_START   (game_START),
    .game_ROUND   (game_ROUND),
    .game_GAME    (game_GAME),
    .wins_p1      (wins_p1),
    .wins_p2      (wins_p2),
    .games_played (games_played),
    .busy         (busy),
    .match_done   (match_done),
    .match_winner (match_winner),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Core stand-in: the result of a move appears during the cycle after it was driven.
  always @(posedge clk) begin
    #1;
    game_GAME = 2'b00;
    if (prev_drive && res_q.size() != 0) game_GAME = res_q.pop_front();
    prev_drive = (game_P1 != 2'b00);
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (game_START) start_cnt++;
      if (game_P1 != 2'b00) cap_q.push_back({game_P1, game_P2});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] b);
    int n = 0;
    @(negedge clk);
    while (!mif.cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n == 300) chk("push_wait", {31'd0, mif.cmd_ready}, 1);
    mif.cmd_valid = 1'b1;
    mif.cmd_p1    = a;
    mif.cmd_p2    = b;
    @(posedge clk);
    #1 mif.cmd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_cnt   = 0;
    match_start = 1'b1;
    @(negedge clk);
    match_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!match_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", {31'd0, match_done}, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; match_start = 1'b0; game_ROUND = 2'b00; game_GAME = 2'b00;
    mif.cmd_valid = 1'b0; mif.cmd_p1 = 2'b00; mif.cmd_p2 = 2'b00;
    do_reset();

    chk("rst_p1", {30'd0, game_P1}, 0);
    chk("rst_start", {31'd0, game_START}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, match_done}, 0);
    chk("rst_winner", {30'd0, match_winner}, 0);
    chk("rst_games", {28'd0, games_played}, 0);
    chk("rst_ready", {31'd0, mif.cmd_ready}, 1);

    // Fill the FIFO without a match running; the fifth offer must bounce.
    push(2'b01, 2'b10); push(2'b10, 2'b11); push(2'b11, 2'b01); push(2'b01, 2'b11);
    @(negedge clk);
    chk("full_ready", {31'd0, mif.cmd_ready}, 0);
    mif.cmd_valid = 1'b1; mif.cmd_p1 = 2'b10; mif.cmd_p2 = 2'b10;
    repeat (3) @(negedge clk);
    chk("full_hold_ready", {31'd0, mif.cmd_ready}, 0);
    mif.cmd_valid = 1'b0;

    // Best-of-3 won 2-0 by P1.
    res_q = '{2'b01, 2'b01};
    pulse_start();
    wait_done(100);
    chk("m1_wins_p1", {28'd0, wins_p1}, 2);
    chk("m1_wins_p2", {28'd0, wins_p2}, 0);
    chk("m1_games", {28'd0, games_played}, 2);
    chk("m1_winner", {30'd0, match_winner}, 2'b01);
    chk("m1_starts", start_cnt, 2);
    chk("m1_busy", {31'd0, busy}, 0);
    chk("m1_cap_n", cap_q.size(), 2);
    chk("m1_cap0", {28'd0, cap_q[0]}, 4'b0110);
    chk("m1_cap1", {28'd0, cap_q[1]}, 4'b1011);

    // Restart from DONE: tallies clear, START pulses for a single cycle.
    res_q = '{2'b11, 2'b10, 2'b01};
    pulse_start();
    chk("m2_start_hi", {31'd0, game_START}, 1);
    chk("m2_clr_wins", {28'd0, wins_p1}, 0);
    chk("m2_clr_games", {28'd0, games_played}, 0);
    chk("m2_clr_winner", {30'd0, match_winner}, 0);
    chk("m2_busy", {31'd0, busy}, 1);
    @(negedge clk);
    chk("m2_start_lo", {31'd0, game_START}, 0);

    repeat (10) @(negedge clk);
    chk("m2_busy_mid", {31'd0, busy}, 1);
    match_start = 1'b1;
    @(negedge clk);
    match_start = 1'b0;
    push(2'b10, 2'b01);
    wait_done(100);
    chk("m2_wins_p1", {28'd0, wins_p1}, 1);
    chk("m2_wins_p2", {28'd0, wins_p2}, 1);
    chk("m2_games", {28'd0, games_played}, 3);
    chk("m2_winner", {30'd0, match_winner}, 2'b11);
    chk("m2_starts", start_cnt, 3);
    chk("m2_cap_n", cap_q.size(), 5);
    chk("m2_cap2", {28'd0, cap_q[2]}, 4'b1101);
    chk("m2_cap3", {28'd0, cap_q[3]}, 4'b0111);
    chk("m2_cap4", {28'd0, cap_q[4]}, 4'b1001);

    // Timeout: core never reports a result for 24 moves.
    do_reset();
    base = cap_q.size();
    res_q.delete();
    pulse_start();
    for (int i = 0; i < 24; i++) push(2'(i % 3 + 1), 2'((i + 1) % 3 + 1));
    wait_done(300);
    chk("to_err", {31'd0, timeout_err}, 1);
    chk("to_winner", {30'd0, match_winner}, 0);
    chk("to_games", {28'd0, games_played}, 0);
    chk("to_moves", cap_q.size() - base, 24);
    chk("to_starts", start_cnt, 1);

    // Async reset in the middle of DRIVE drops everything, including queued moves.
    push(2'b01, 2'b01); push(2'b10, 2'b10);
    pulse_start();
    begin
      int n = 0;
      while (game_P1 == 2'b00 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mr_in_drive", {31'd0, (game_P1 != 2'b00)}, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_p1", {30'd0, game_P1}, 0);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_ready", {31'd0, mif.cmd_ready}, 1);
    chk("mr_terr", {31'd0, timeout_err}, 0);
    chk("mr_done", {31'd0, match_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = cap_q.size();
    pulse_start();
    repeat (8) @(negedge clk);
    chk("mr_fifo_lost", cap_q.size() - base, 0);
    chk("mr_wait_busy", {31'd0, busy}, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
